// File: rtl/cpu_io_pkg.sv
// Shared CPU-side I/O definitions: delivery FSM encodings and handshake levels.
// Used by the input port now and by the output port later.
package cpu_io_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DELIVER  = 2'd1,
    S_WAIT_REL = 2'd2
  } io_state_e;

  localparam logic STATUS_REQ  = 1'b1;
  localparam logic CTRL_STROBE = 1'b1;
  localparam logic CTRL_IDLE   = 1'b0;

endpackage

// File: rtl/cpu_in_port_if.sv
// Bundle between the external producer / CPU and the input port.
// The master drives the producer, flush and CPU request; the slave is the port itself.
interface cpu_in_port_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4
);
  logic [DATA_WIDTH-1:0]    ext_data;
  logic                     ext_valid;
  logic                     ext_ready;
  logic                     flush;
  logic                     cpu_status;
  logic [DATA_WIDTH-1:0]    cpu_in;
  logic                     cpu_control;
  logic [$clog2(DEPTH):0]   level;

  modport master (
    output ext_data, ext_valid, flush, cpu_status,
    input  ext_ready, cpu_in, cpu_control, level
  );

  modport slave (
    input  ext_data, ext_valid, flush, cpu_status,
    output ext_ready, cpu_in, cpu_control, level
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with level count, sync flush and no read bypass.
// Write is ready while not full; read data is the head, valid while not empty.
module sync_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush_i,
  input  logic                    wr_vld_i,
  input  logic [DATA_WIDTH-1:0]   wr_dat_i,
  output logic                    wr_rdy_o,
  input  logic                    rd_en_i,
  output logic [DATA_WIDTH-1:0]   rd_dat_o,
  output logic [$clog2(DEPTH):0]  level_o,
  output logic                    full_o,
  output logic                    empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  push, pop;

  assign full_o   = (level_q == FULL_LVL);
  assign empty_o  = (level_q == '0);
  assign wr_rdy_o = !full_o;
  assign level_o  = level_q;
  assign rd_dat_o = mem_q[rd_ptr_q];

  // Flush wins over any push or pop on the same edge.
  assign push = wr_vld_i && !full_o && !flush_i;
  assign pop  = rd_en_i && !empty_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_dat_i;
  end
endmodule

// File: rtl/cpu_in_port.sv
// Buffers producer words and hands the CPU one word per status request with a one-cycle control strobe.
// Delivery registered one edge after the request; producer stalled only while the FIFO is full.
module cpu_in_port
  import cpu_io_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  cpu_in_port_if.slave  bus
);
  io_state_e              state_q;
  logic [DATA_WIDTH-1:0]  cpu_in_q;
  logic                   cpu_control_q;
  logic [DATA_WIDTH-1:0]  head_dat;
  logic [$clog2(DEPTH):0] fifo_level;
  logic                   fifo_rdy, fifo_full, fifo_empty;
  logic                   pop_req;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush_i  (bus.flush),
    .wr_vld_i (bus.ext_valid),
    .wr_dat_i (bus.ext_data),
    .wr_rdy_o (fifo_rdy),
    .rd_en_i  (pop_req),
    .rd_dat_o (head_dat),
    .level_o  (fifo_level),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  assign pop_req         = (state_q == S_IDLE) && (bus.cpu_status == STATUS_REQ) && !fifo_empty;
  assign bus.ext_ready   = fifo_rdy;
  assign bus.level       = fifo_level;
  assign bus.cpu_in      = cpu_in_q;
  assign bus.cpu_control = cpu_control_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cpu_in_q      <= '0;
      cpu_control_q <= CTRL_IDLE;
    end else if (bus.flush) begin
      // cpu_in deliberately keeps the last delivered word across a flush.
      state_q       <= S_IDLE;
      cpu_control_q <= CTRL_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          cpu_control_q <= CTRL_IDLE;
          if (pop_req) begin
            state_q       <= S_DELIVER;
            cpu_in_q      <= head_dat;
            cpu_control_q <= CTRL_STROBE;
          end
        end
        S_DELIVER: begin
          state_q       <= S_WAIT_REL;
          cpu_control_q <= CTRL_IDLE;
        end
        S_WAIT_REL: begin
          cpu_control_q <= CTRL_IDLE;
          if (bus.cpu_status != STATUS_REQ) state_q <= S_IDLE;
        end
        default: begin
          state_q       <= S_IDLE;
          cpu_control_q <= CTRL_IDLE;
        end
      endcase
    end
  end

  logic unused_full;
  assign unused_full = fifo_full;
endmodule

// File: tb/tb_cpu_in_port.sv
// Directed bench for cpu_in_port: request/strobe timing, full/wrap ordering, flush and async reset.
module tb_cpu_in_port;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_bad = 0;

  cpu_in_port_if #(.DATA_WIDTH(16), .DEPTH(4)) bus ();

  cpu_in_port #(.DATA_WIDTH(16), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request one word; expects the strobe on the first edge, then releases the request.
  task automatic deliver(output logic [15:0] w);
    logic seen;
    seen = 1'b0;
    w = '0;
    bus.cpu_status = 1'b1;
    for (int i = 0; i < 6 && !seen; i++) begin
      tick();
      if (bus.cpu_control) begin
        seen = 1'b1;
        w = bus.cpu_in;
      end
    end
    chk("dlv_strobe", 32'(seen), 32'd1);
    bus.cpu_status = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    logic [15:0] w;
    logic [15:0] words [6];
    int strobes;

    bus.ext_data   = '0;
    bus.ext_valid  = 1'b0;
    bus.flush      = 1'b0;
    bus.cpu_status = 1'b0;

    // Reset state
    #2;
    chk("rst_ready",   32'(bus.ext_ready),   32'd1);
    chk("rst_level",   32'(bus.level),       32'd0);
    chk("rst_control", 32'(bus.cpu_control), 32'd0);
    chk("rst_cpu_in",  32'(bus.cpu_in),      32'd0);
    #20 rst_n = 1'b1;
    tick();

    // Held request gets exactly one word
    bus.ext_valid = 1'b1;
    bus.ext_data  = 16'h1234; tick();
    bus.ext_data  = 16'hBEEF; tick();
    bus.ext_valid = 1'b0;
    chk("push2_level", 32'(bus.level), 32'd2);
    bus.cpu_status = 1'b1;
    tick();
    chk("req1_ctrl",  32'(bus.cpu_control), 32'd1);
    chk("req1_data",  32'(bus.cpu_in),      32'h1234);
    chk("req1_level", 32'(bus.level),       32'd1);
    strobes = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.cpu_control) strobes++;
    end
    chk("held_no_2nd", 32'(strobes), 32'd0);
    chk("held_level",  32'(bus.level), 32'd1);
    bus.cpu_status = 1'b0; tick();
    bus.cpu_status = 1'b1; tick();
    chk("req2_ctrl", 32'(bus.cpu_control), 32'd1);
    chk("req2_data", 32'(bus.cpu_in),      32'hBEEF);
    bus.cpu_status = 1'b0; tick(); tick();

    // Request while empty: serviced one edge after the push, not on it
    bus.cpu_status = 1'b1; tick();
    chk("empty_no_ctrl", 32'(bus.cpu_control), 32'd0);
    bus.ext_valid = 1'b1;
    bus.ext_data  = 16'h00A5; tick();
    bus.ext_valid = 1'b0;
    chk("nobypass_ctrl",  32'(bus.cpu_control), 32'd0);
    chk("nobypass_level", 32'(bus.level),       32'd1);
    tick();
    chk("late_ctrl", 32'(bus.cpu_control), 32'd1);
    chk("late_data", 32'(bus.cpu_in),      32'h00A5);
    bus.cpu_status = 1'b0; tick(); tick();

    // Full: five words offered back to back
    bus.ext_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.ext_data = 16'h1001 + 16'(i);
      tick();
    end
    chk("full_level", 32'(bus.level),     32'd4);
    chk("full_ready", 32'(bus.ext_ready), 32'd0);
    bus.ext_data = 16'h1005; tick();
    chk("full_stall_level", 32'(bus.level), 32'd4);
    bus.cpu_status = 1'b1; tick();
    chk("full_pop_ctrl",  32'(bus.cpu_control), 32'd1);
    chk("full_pop_data",  32'(bus.cpu_in),      32'h1001);
    chk("full_pop_level", 32'(bus.level),       32'd3);
    chk("full_pop_ready", 32'(bus.ext_ready),   32'd1);
    bus.cpu_status = 1'b0; tick();
    chk("fifth_accepted", 32'(bus.level), 32'd4);
    bus.ext_valid = 1'b0; tick();
    for (int i = 0; i < 4; i++) begin
      deliver(w);
      chk("full_drain", 32'(w), 32'h1002 + 32'(i));
    end

    // Wrap-around ordering: 6 words, pop whenever full
    for (int i = 0; i < 6; i++) words[i] = 16'h2000 + 16'(i * 16'h0111);
    bus.ext_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.ext_data = words[i];
      tick();
    end
    bus.ext_valid = 1'b0;
    deliver(w); chk("wrap_d0", 32'(w), 32'(words[0]));
    bus.ext_valid = 1'b1; bus.ext_data = words[4]; tick(); bus.ext_valid = 1'b0;
    deliver(w); chk("wrap_d1", 32'(w), 32'(words[1]));
    bus.ext_valid = 1'b1; bus.ext_data = words[5]; tick(); bus.ext_valid = 1'b0;
    chk("wrap_level", 32'(bus.level), 32'd4);
    for (int i = 2; i < 6; i++) begin
      deliver(w);
      chk("wrap_order", 32'(w), 32'(words[i]));
    end
    chk("wrap_empty", 32'(bus.level), 32'd0);

    // Flush drops buffered words and a coincident push, keeps cpu_in
    bus.ext_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.ext_data = 16'h3A00 + 16'(i);
      tick();
    end
    bus.ext_valid = 1'b0;
    deliver(w); chk("fl_first", 32'(w), 32'h3A00);
    bus.flush = 1'b1; bus.ext_valid = 1'b1; bus.ext_data = 16'hDEAD;
    tick();
    bus.flush = 1'b0; bus.ext_valid = 1'b0;
    chk("fl_level",  32'(bus.level),  32'd0);
    chk("fl_cpu_in", 32'(bus.cpu_in), 32'h3A00);
    bus.cpu_status = 1'b1;
    strobes = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.cpu_control) strobes++;
    end
    chk("fl_no_strobe", 32'(strobes), 32'd0);
    bus.ext_valid = 1'b1; bus.ext_data = 16'h0777; tick();
    bus.ext_valid = 1'b0; tick();
    chk("fl_new_ctrl", 32'(bus.cpu_control), 32'd1);
    chk("fl_new_data", 32'(bus.cpu_in),      32'h0777);
    bus.cpu_status = 1'b0; tick(); tick();

    // Async reset in the strobe cycle
    bus.ext_valid = 1'b1; bus.ext_data = 16'h5A5A; tick();
    bus.ext_valid = 1'b0;
    bus.cpu_status = 1'b1; tick();
    chk("pre_rst_ctrl", 32'(bus.cpu_control), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_ctrl",   32'(bus.cpu_control), 32'd0);
    chk("arst_cpu_in", 32'(bus.cpu_in),      32'd0);
    chk("arst_level",  32'(bus.level),       32'd0);
    chk("arst_ready",  32'(bus.ext_ready),   32'd1);
    #2 rst_n = 1'b1;
    strobes = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.cpu_control) strobes++;
    end
    chk("post_rst_no_strobe", 32'(strobes), 32'd0);
    bus.cpu_status = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
